jogador_automatico: RTL and testbench
=====================================

JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 Parameter DEPTH, 16, number of 4-bit entries in the sequence buffer (power of 2, 2..16).
REQ-002 Parameter T_PRESS, 2500, clock cycles a button is held high per replayed press (>=1).
REQ-003 Parameter T_GAP, 2500, clock cycles all buttons are held low between presses (>=1).
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 habilita  in  1  level; enables the player; low forces OCIOSO.
REQ-007 leds  in  4  game LED outputs observed during sequence display.
REQ-008 responder  in  1  one-cycle pulse; the game is waiting for player input.
REQ-009 erra_ultima  in  1  error-injection request, sampled with responder (see Configuration).
REQ-010 botoes  out  4  emulated button lines driven into the game.
REQ-011 ocupado  out  1  high in PRESSIONA and SOLTA.
REQ-012 pronto  out  1  one-cycle pulse on replay completion.
REQ-013 overflow  out  1  sticky; a capture was dropped because the buffer was full.
REQ-014 db_contagem  out  5  number of captured entries (0..DEPTH).
REQ-015 db_estado  out  3  state code: OCIOSO=0, CAPTURA=1, PRESSIONA=2, SOLTA=3, FIM=4.

Function
REQ-016 The block SHALL be a Moore FSM with states OCIOSO, CAPTURA, PRESSIONA, SOLTA and FIM; all outputs are registered or decoded from state.
REQ-017 OCIOSO: botoes=0, count=0; habilita=1 -> CAPTURA.
REQ-018 A capture edge SHALL be a cycle in which leds!=0 and leds was 0 in the previous cycle; the previous-value register updates every cycle in every state.
REQ-019 CAPTURA: on a capture edge with count<DEPTH, leds SHALL be written to buf[count] and count incremented in the same cycle; the value is stored as-is, even if not one-hot.
REQ-020 CAPTURA: on a capture edge with count==DEPTH, the value is discarded, count is held and overflow is set.
REQ-021 CAPTURA: on responder=1 -> PRESSIONA with idx=0 and timer=0 if count>0, else -> FIM.
REQ-022 A capture edge coincident with responder SHALL be stored first; the replay includes it.
REQ-023 Capture edges outside CAPTURA SHALL be ignored, so the game's echo of the emulated presses is never recorded.
REQ-024 PRESSIONA: botoes=buf[idx] for exactly T_PRESS cycles, then -> SOLTA with timer=0.
REQ-025 SOLTA: botoes=0 for exactly T_GAP cycles; then idx++ and -> PRESSIONA, or -> FIM if idx==count-1.
REQ-026 The first press SHALL appear on botoes in the cycle after responder is sampled (1-cycle latency).
REQ-027 FIM: pronto=1 for one cycle, count:=0 (the buffer is rebuilt each round), then -> CAPTURA.
REQ-028 habilita=0 in any state SHALL force OCIOSO on the next edge: botoes=0, count=0, pronto not asserted; overflow is retained.
REQ-029 responder outside CAPTURA SHALL be ignored.
REQ-030 The timer width SHALL be $clog2(max(T_PRESS,T_GAP)+1); idx width $clog2(DEPTH).

Reset
REQ-031 reset=1 SHALL force the following on the next edge, overriding all other inputs: state=OCIOSO, botoes=0, ocupado=0, pronto=0, overflow=0, count=0, idx=0, timer=0, and the previous-leds register=0.
REQ-032 Buffer contents are not cleared by reset; they are unreadable until rewritten.

Configuration
REQ-033 Macro JOGADOR_ERRO_EN defined: if erra_ultima=1 when responder is accepted, the last replayed press SHALL be buf[count-1] rotated left by 1 bit; all other presses are unchanged.
REQ-034 Macro JOGADOR_ERRO_EN undefined: the erra_ultima port SHALL still exist but is ignored, and the replay is always exact.

Verification (DEPTH=4, T_PRESS=4, T_GAP=2)
REQ-035 Reset mid-PRESSIONA -> next cycle botoes=0, db_estado=0, db_contagem=0, overflow=0.
REQ-036 habilita=1; leds pulses 0001, 0100, 1000 separated by zeros; responder -> botoes=0001 (4 cyc), 0 (2), 0100 (4), 0 (2), 1000 (4), 0 (2), then pronto for 1 cycle, db_contagem=0.
REQ-037 Five distinct leds pulses, then responder -> overflow=1, db_contagem=4, only the first four values replayed.
REQ-038 leds held at 0010 for 10 cycles -> exactly one capture; leds stepping 0010->0011 with no zero between -> no second capture.
REQ-039 responder with count=0 -> no press, pronto one cycle later; habilita dropped during SOLTA -> OCIOSO next cycle, no pronto.
REQ-040 With JOGADOR_ERRO_EN, erra_ultima=1, buffer {0001,1000} -> replay 0001 then 0001; without the macro -> 0001 then 1000.

Source files
------------

// File: rtl/jogador_automatico.sv
// Automatic player: records the LED sequence shown by the game, then replays it on the button lines.
// Optional JOGADOR_ERRO_EN: rotate the last replayed press left by one bit when erra_ultima is set.
module jogador_automatico #(
  parameter int DEPTH   = 16,
  parameter int T_PRESS = 2500,
  parameter int T_GAP   = 2500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] leds,
  input  logic       responder,
  input  logic       erra_ultima,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic       pronto,
  output logic       overflow,
  output logic [4:0] db_contagem,
  output logic [2:0] db_estado
);

  localparam int TMAX = (T_PRESS > T_GAP) ? T_PRESS : T_GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    CAPTURA   = 3'd1,
    PRESSIONA = 3'd2,
    SOLTA     = 3'd3,
    FIM       = 3'd4
  } EstadoT;

  EstadoT          estado, proximo;
  logic [3:0]      seqBuf [DEPTH];
  logic [3:0]      ledsPrev;
  logic [4:0]      count;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   timer;
  logic            captureEdge, bufFull, lastIdx, pressDone, gapDone;
  logic [3:0]      pressVal;

  assign captureEdge = (leds != 4'd0) && (ledsPrev == 4'd0);
  assign bufFull     = (count >= 5'(DEPTH));
  assign lastIdx     = (5'(idx) == count - 5'd1);
  assign pressDone   = (timer == TW'(T_PRESS - 1));
  assign gapDone     = (timer == TW'(T_GAP - 1));

  always_ff @(posedge clock) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:    if (habilita) proximo = CAPTURA;
      // A capture landing in the same cycle as responder counts as a stored entry.
      CAPTURA:   if (responder) proximo = (count != 5'd0 || captureEdge) ? PRESSIONA : FIM;
      PRESSIONA: if (pressDone) proximo = SOLTA;
      SOLTA:     if (gapDone) proximo = lastIdx ? FIM : PRESSIONA;
      FIM:       proximo = CAPTURA;
      default:   proximo = OCIOSO;
    endcase
    if (!habilita) proximo = OCIOSO;
  end

`ifdef JOGADOR_ERRO_EN
  logic errLatch;
`else
  logic unusedErra;
  assign unusedErra = erra_ultima;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      ledsPrev <= 4'd0;
      count    <= 5'd0;
      idx      <= '0;
      timer    <= '0;
      overflow <= 1'b0;
`ifdef JOGADOR_ERRO_EN
      errLatch <= 1'b0;
`endif
    end else begin
      ledsPrev <= leds;
      if (!habilita) begin
        count <= 5'd0;
        idx   <= '0;
        timer <= '0;
      end else begin
        case (estado)
          OCIOSO: begin
            count <= 5'd0;
            idx   <= '0;
            timer <= '0;
          end
          CAPTURA: begin
            if (captureEdge) begin
              if (!bufFull) count <= count + 5'd1;
              else          overflow <= 1'b1;
            end
            if (responder) begin
              idx   <= '0;
              timer <= '0;
`ifdef JOGADOR_ERRO_EN
              errLatch <= erra_ultima;
`endif
            end
          end
          PRESSIONA: timer <= pressDone ? '0 : timer + TW'(1);
          SOLTA: begin
            if (gapDone) begin
              timer <= '0;
              if (!lastIdx) idx <= idx + IW'(1);
            end else begin
              timer <= timer + TW'(1);
            end
          end
          FIM:     count <= 5'd0;
          default: ;
        endcase
      end
    end
  end

  // Buffer is deliberately not reset; entries are only read after being rewritten.
  always_ff @(posedge clock) begin
    if (!reset && habilita && estado == CAPTURA && captureEdge && !bufFull)
      seqBuf[count[IW-1:0]] <= leds;
  end

  always_comb begin
    pressVal = seqBuf[idx];
`ifdef JOGADOR_ERRO_EN
    if (errLatch && lastIdx) pressVal = {pressVal[2:0], pressVal[3]};
`endif
    botoes  = (estado == PRESSIONA) ? pressVal : 4'd0;
    ocupado = (estado == PRESSIONA) || (estado == SOLTA);
    pronto  = (estado == FIM);
  end

  assign db_contagem = count;
  assign db_estado   = estado;

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico with DEPTH=4, T_PRESS=4, T_GAP=2.
module tb_jogador_automatico;
  logic       clock = 1'b0;
  logic       reset, habilita, responder, erra_ultima;
  logic [3:0] leds, botoes;
  logic       ocupado, pronto, overflow;
  logic [4:0] db_contagem;
  logic [2:0] db_estado;

  int passCount = 0;
  int totalCount = 0;
  logic [3:0] obs_q[$];
  logic [3:0] exp_q[$];

  jogador_automatico #(.DEPTH(4), .T_PRESS(4), .T_GAP(2)) dut (
    .clock(clock), .reset(reset), .habilita(habilita), .leds(leds),
    .responder(responder), .erra_ultima(erra_ultima), .botoes(botoes),
    .ocupado(ocupado), .pronto(pronto), .overflow(overflow),
    .db_contagem(db_contagem), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v);
    leds = v;
    step();
    leds = 4'd0;
    step();
  endtask

  // Drops responder/erra_ultima after the first edge and records botoes each cycle.
  task automatic record_cycles(input int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      step();
      responder = 1'b0;
      erra_ultima = 1'b0;
      obs_q.push_back(botoes);
    end
  endtask

  task automatic build_exp(input logic [3:0] v);
    repeat (4) exp_q.push_back(v);
    repeat (2) exp_q.push_back(4'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1; habilita = 1'b0; leds = 4'd0; responder = 1'b0; erra_ultima = 1'b0;
    step(); step();
    reset = 1'b0;
    totalCount++;
    if ({db_estado, botoes, ocupado, pronto, overflow, db_contagem} !== 15'd0)
      $display("FAIL reset_state: got %h expected 0", {db_estado, botoes, ocupado, pronto, overflow, db_contagem});
    else passCount++;
  endtask

  task automatic test_replay();
    habilita = 1'b1;
    step();
    totalCount++;
    if (db_estado !== 3'd1) $display("FAIL enter_captura: got %0d expected 1", db_estado);
    else passCount++;
    pulse(4'b0001); pulse(4'b0100); pulse(4'b1000);
    totalCount++;
    if (db_contagem !== 5'd3) $display("FAIL replay_count: got %0d expected 3", db_contagem);
    else passCount++;
    exp_q.delete();
    build_exp(4'b0001); build_exp(4'b0100); build_exp(4'b1000);
    responder = 1'b1;
    record_cycles(18);
    for (int i = 0; i < 18; i++) begin
      totalCount++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL replay_botoes[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      else passCount++;
    end
    step();
    totalCount++;
    if (pronto !== 1'b1 || db_estado !== 3'd4) $display("FAIL replay_pronto: got pronto=%b estado=%0d expected 1/4", pronto, db_estado);
    else passCount++;
    step();
    totalCount++;
    if (pronto !== 1'b0 || db_contagem !== 5'd0 || db_estado !== 3'd1)
      $display("FAIL replay_after: got pronto=%b cnt=%0d estado=%0d expected 0/0/1", pronto, db_contagem, db_estado);
    else passCount++;
  endtask

  task automatic test_overflow();
    pulse(4'b0001); pulse(4'b0010); pulse(4'b0100); pulse(4'b1000); pulse(4'b0011);
    totalCount++;
    if (overflow !== 1'b1 || db_contagem !== 5'd4)
      $display("FAIL overflow_flag: got ovf=%b cnt=%0d expected 1/4", overflow, db_contagem);
    else passCount++;
    exp_q.delete();
    build_exp(4'b0001); build_exp(4'b0010); build_exp(4'b0100); build_exp(4'b1000);
    responder = 1'b1;
    record_cycles(24);
    for (int i = 0; i < 24; i++) begin
      totalCount++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL overflow_botoes[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      else passCount++;
    end
    step();
    totalCount++;
    if (pronto !== 1'b1) $display("FAIL overflow_pronto: got %b expected 1", pronto);
    else passCount++;
    step();
  endtask

  task automatic test_hold();
    leds = 4'b0010;
    repeat (10) step();
    leds = 4'b0011;
    repeat (2) step();
    leds = 4'd0;
    step();
    totalCount++;
    if (db_contagem !== 5'd1) $display("FAIL hold_count: got %0d expected 1", db_contagem);
    else passCount++;
    exp_q.delete();
    build_exp(4'b0010);
    responder = 1'b1;
    record_cycles(6);
    for (int i = 0; i < 6; i++) begin
      totalCount++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL hold_botoes[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      else passCount++;
    end
    step(); step();
  endtask

  task automatic test_empty();
    responder = 1'b1;
    step();
    responder = 1'b0;
    totalCount++;
    if (db_estado !== 3'd4 || pronto !== 1'b1 || botoes !== 4'd0 || ocupado !== 1'b0)
      $display("FAIL empty_fim: got estado=%0d pronto=%b botoes=%b ocupado=%b expected 4/1/0000/0", db_estado, pronto, botoes, ocupado);
    else passCount++;
    step();
    totalCount++;
    if (pronto !== 1'b0 || db_estado !== 3'd1) $display("FAIL empty_after: got pronto=%b estado=%0d expected 0/1", pronto, db_estado);
    else passCount++;
  endtask

  task automatic test_coincident();
    leds = 4'b0100;
    responder = 1'b1;
    record_cycles(6);
    leds = 4'd0;
    totalCount++;
    if (db_contagem !== 5'd1) $display("FAIL coincident_count: got %0d expected 1", db_contagem);
    else passCount++;
    exp_q.delete();
    build_exp(4'b0100);
    for (int i = 0; i < 6; i++) begin
      totalCount++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL coincident_botoes[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      else passCount++;
    end
    step();
    totalCount++;
    if (pronto !== 1'b1) $display("FAIL coincident_pronto: got %b expected 1", pronto);
    else passCount++;
    step();
  endtask

  task automatic test_error();
    pulse(4'b0001); pulse(4'b1000);
    exp_q.delete();
    build_exp(4'b0001);
`ifdef JOGADOR_ERRO_EN
    build_exp(4'b0001);
`else
    build_exp(4'b1000);
`endif
    erra_ultima = 1'b1;
    responder = 1'b1;
    record_cycles(12);
    for (int i = 0; i < 12; i++) begin
      totalCount++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL error_botoes[%0d]: got %b expected %b", i, obs_q[i], exp_q[i]);
      else passCount++;
    end
    step(); step();
  endtask

  task automatic test_abort();
    logic sawPronto;
    pulse(4'b0001); pulse(4'b0010);
    responder = 1'b1;
    record_cycles(5);
    totalCount++;
    if (db_estado !== 3'd3 || ocupado !== 1'b1) $display("FAIL abort_in_solta: got estado=%0d ocupado=%b expected 3/1", db_estado, ocupado);
    else passCount++;
    habilita = 1'b0;
    step();
    totalCount++;
    if (db_estado !== 3'd0 || pronto !== 1'b0 || botoes !== 4'd0 || db_contagem !== 5'd0 || overflow !== 1'b1)
      $display("FAIL abort_ocioso: got estado=%0d pronto=%b botoes=%b cnt=%0d ovf=%b expected 0/0/0000/0/1",
               db_estado, pronto, botoes, db_contagem, overflow);
    else passCount++;
    sawPronto = 1'b0;
    repeat (4) begin
      step();
      if (pronto) sawPronto = 1'b1;
    end
    totalCount++;
    if (sawPronto !== 1'b0 || db_estado !== 3'd0) $display("FAIL abort_no_pronto: got pronto_seen=%b estado=%0d expected 0/0", sawPronto, db_estado);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    habilita = 1'b1;
    step();
    pulse(4'b0001);
    responder = 1'b1;
    step();
    responder = 1'b0;
    step();
    totalCount++;
    if (db_estado !== 3'd2 || botoes !== 4'b0001) $display("FAIL mid_pressiona: got estado=%0d botoes=%b expected 2/0001", db_estado, botoes);
    else passCount++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    totalCount++;
    if (botoes !== 4'd0 || db_estado !== 3'd0 || db_contagem !== 5'd0 || overflow !== 1'b0)
      $display("FAIL mid_reset: got botoes=%b estado=%0d cnt=%0d ovf=%b expected 0000/0/0/0", botoes, db_estado, db_contagem, overflow);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_replay();
    test_overflow();
    test_hold();
    test_empty();
    test_coincident();
    test_error();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule
